// File: rtl/snes_pad_if.sv
// -----------------------------------------------------------------------------
// snes_pad_if
// Pad-side pin bundle of the SNES/NES serial controller protocol.
//   latch_in : host latch pin (asynchronous, active-high)
//   pclk_in  : host pad clock pin (asynchronous, idles high)
//   data_out : serial data pin driven by the pad (active-low, 0 = pressed)
// Modports:
//   master : the host/console side (drives latch and clock, reads data)
//   slave  : the pad side (reads latch and clock, drives data)
// -----------------------------------------------------------------------------
interface snes_pad_if;
    logic latch_in;
    logic pclk_in;
    logic data_out;

    modport master (
        output latch_in,
        output pclk_in,
        input  data_out
    );

    modport slave (
        input  latch_in,
        input  pclk_in,
        output data_out
    );
endinterface

// File: rtl/snes_pad_emulator.sv
// -----------------------------------------------------------------------------
// snes_pad_emulator
// Controller-side responder for the SNES/NES serial pad protocol. The host
// drives latch and pad clock; this block presents a NUM_BITS-wide button word
// MSB first on the active-low data pin.
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high
//   pad        : snes_pad_if.slave (latch_in, pclk_in in; data_out out)
//   buttons    : button state, 1 = pressed, bit NUM_BITS-1 sent first
//   busy       : high while in LATCH or SHIFT
//   frame_done : one-cycle pulse when the last bit has been consumed
//
// Parameters:
//   SYNC_STAGES    : synchronizer depth on latch/pclk (values below 2 use 2)
//   NUM_BITS       : bits per frame
//   TIMEOUT_CYCLES : watchdog limit in clk cycles
//
// Optional feature: define SNES_PAD_WATCHDOG_EN to build a stall watchdog
// that returns the FSM to IDLE after TIMEOUT_CYCLES cycles without any
// latch or pad clock edge while in LATCH or SHIFT.
// -----------------------------------------------------------------------------
module snes_pad_emulator #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_BITS       = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    snes_pad_if.slave           pad,
    input  logic [NUM_BITS-1:0] buttons,
    output logic                busy,
    output logic                frame_done
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CW     = $clog2(NUM_BITS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [SYNC_N-1:0]   latch_sync_r;
    logic [SYNC_N-1:0]   pclk_sync_r;
    logic                latch_prev_r;
    logic                pclk_prev_r;
    logic                latch_rise_s;
    logic                latch_fall_s;
    logic                pclk_rise_s;

    logic [1:0]          state_r;
    logic [CW-1:0]       count_r;
    logic [NUM_BITS-1:0] shift_r;
    logic                data_out_r;
    logic                busy_r;
    logic                frame_done_r;

    logic [1:0]          state_nxt_s;
    logic [CW-1:0]       count_nxt_s;
    logic [NUM_BITS-1:0] shift_nxt_s;
    logic [NUM_BITS-1:0] shift_dn_s;
    logic                data_nxt_s;
    logic                done_nxt_s;
    logic                timeout_s;

    // Synchronizers and edge-detect flops; pclk idles high so reset values
    // match the idle pins and no edge appears when reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_sync_r <= {SYNC_N{1'b0}};
            pclk_sync_r  <= {SYNC_N{1'b1}};
            latch_prev_r <= 1'b0;
            pclk_prev_r  <= 1'b1;
        end else begin
            latch_sync_r <= {latch_sync_r[SYNC_N-2:0], pad.latch_in};
            pclk_sync_r  <= {pclk_sync_r[SYNC_N-2:0], pad.pclk_in};
            latch_prev_r <= latch_sync_r[SYNC_N-1];
            pclk_prev_r  <= pclk_sync_r[SYNC_N-1];
        end
    end

    assign latch_rise_s = latch_sync_r[SYNC_N-1] & ~latch_prev_r;
    assign latch_fall_s = ~latch_sync_r[SYNC_N-1] & latch_prev_r;
    assign pclk_rise_s  = pclk_sync_r[SYNC_N-1] & ~pclk_prev_r;

    // Shifted-out view of the frame; the old MSB has just been consumed.
    assign shift_dn_s = shift_r << 1'b1;

`ifdef SNES_PAD_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            pclk_fall_s;
    logic            any_edge_s;
    logic            wd_active_s;

    assign pclk_fall_s = ~pclk_sync_r[SYNC_N-1] & pclk_prev_r;
    assign any_edge_s  = latch_rise_s | latch_fall_s | pclk_rise_s | pclk_fall_s;
    assign wd_active_s = (state_r == ST_LATCH) || (state_r == ST_SHIFT);
    assign timeout_s   = wd_active_s && !any_edge_s &&
                         (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Stall watchdog: counts idle cycles of the host while a frame is open.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (any_edge_s || !wd_active_s || timeout_s) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end
    end
`else
    // Without the watchdog the FSM waits indefinitely; the timeout parameter
    // stays on the interface so both builds share one parameter list.
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
    assign timeout_s        = 1'b0;
`endif

    // Frame FSM next-state and datapath.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        shift_nxt_s = shift_r;
        data_nxt_s  = data_out_r;
        done_nxt_s  = 1'b0;
        if (timeout_s) begin
            state_nxt_s = ST_IDLE;
            count_nxt_s = {CW{1'b0}};
            data_nxt_s  = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    data_nxt_s = 1'b1;
                    if (latch_rise_s) begin
                        state_nxt_s = ST_LATCH;
                        count_nxt_s = {CW{1'b0}};
                        shift_nxt_s = buttons;
                        data_nxt_s  = ~buttons[NUM_BITS-1];
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LATCH: begin
                    // On the fall cycle the synced latch is already low, so
                    // the value captured on the last high cycle is kept.
                    if (latch_fall_s) begin
                        state_nxt_s = ST_SHIFT;
                        count_nxt_s = {CW{1'b0}};
                    end else begin
                        shift_nxt_s = buttons;
                        data_nxt_s  = ~buttons[NUM_BITS-1];
                    end
                end
                ST_SHIFT: begin
                    // A latch rise takes priority over a coincident pclk rise.
                    if (latch_rise_s) begin
                        state_nxt_s = ST_LATCH;
                        count_nxt_s = {CW{1'b0}};
                        shift_nxt_s = buttons;
                        data_nxt_s  = ~buttons[NUM_BITS-1];
                    end else if (pclk_rise_s) begin
                        shift_nxt_s = shift_dn_s;
                        count_nxt_s = count_r + CW'(1);
                        if (count_r == CW'(NUM_BITS - 1)) begin
                            state_nxt_s = ST_DONE;
                            data_nxt_s  = 1'b1;
                            done_nxt_s  = 1'b1;
                        end else begin
                            data_nxt_s  = ~shift_dn_s[NUM_BITS-1];
                        end
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    data_nxt_s = 1'b1;
                    if (latch_rise_s) begin
                        state_nxt_s = ST_LATCH;
                        count_nxt_s = {CW{1'b0}};
                        shift_nxt_s = buttons;
                        data_nxt_s  = ~buttons[NUM_BITS-1];
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = {CW{1'b0}};
                    data_nxt_s  = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= {CW{1'b0}};
            shift_r      <= {NUM_BITS{1'b0}};
            data_out_r   <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            shift_r      <= shift_nxt_s;
            data_out_r   <= data_nxt_s;
            busy_r       <= (state_nxt_s == ST_LATCH) || (state_nxt_s == ST_SHIFT);
            frame_done_r <= done_nxt_s;
        end
    end

    assign pad.data_out = data_out_r;
    assign busy         = busy_r;
    assign frame_done   = frame_done_r;

endmodule

// File: doc/snes_pad_emulator.md
Name: snes_pad_emulator

Overview:
- Controller-side responder for the SNES/NES serial pad protocol.
- Lets the FPGA act as a game pad toward an external console or host. The host drives latch and clock; this block shifts out a 16-bit button word on the data line.
- Bit order and polarity match the host-side pad reader already in the IO module set, so the two blocks can be looped back directly.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on latch_in and pclk_in (min 2).
- NUM_BITS, 16: bits per frame; count width is clog2(NUM_BITS+1).
- TIMEOUT_CYCLES, 4096: watchdog limit in clk cycles; used only with SNES_PAD_WATCHDOG_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- latch_in  in  1  host latch pin, asynchronous, active-high
- pclk_in  in  1  host pad clock pin, asynchronous, idles high
- buttons  in  NUM_BITS  button state, 1 = pressed; bit NUM_BITS-1 is sent first
- data_out  out  1  serial data pin, active-low (0 = pressed)
- busy  out  1  high in LATCH or SHIFT state
- frame_done  out  1  one-cycle pulse when the last bit has been consumed

Behaviour:
- Reset:
  - data_out=1, busy=0, frame_done=0, state=IDLE, count=0, shift register=0.
  - Synchronizer chains reset to latch=0 and pclk=1, so releasing reset produces no false edge.
- Inputs:
  - latch_in and pclk_in each pass through SYNC_STAGES flops, then a one-flop edge detector.
  - Pin-to-data_out latency is SYNC_STAGES+1 clk cycles.
- States: IDLE, LATCH, SHIFT, DONE.
  - IDLE: data_out=1. Synced latch rise -> LATCH.
  - LATCH: shift register loads buttons every cycle. data_out = ~buttons[NUM_BITS-1], registered. pclk edges are ignored. Synced latch fall -> SHIFT with count=0; the value loaded on the last latch-high cycle is kept.
  - SHIFT: on each synced pclk rising edge, shift left with 0 fill, count+1, data_out = ~new MSB. When count reaches NUM_BITS -> DONE.
  - DONE: data_out=1, frame_done pulses on the entry cycle. Further pclk edges are ignored. Latch rise -> LATCH.
- Bit 15 is valid before the first pclk rise. After 15 rises all 16 bits have been presented; the 16th rise ends the frame.
- Simultaneous synced latch rise and pclk rise: latch wins, pclk edge dropped.
- Latch rise while in SHIFT: abort, go to LATCH, count=0, no frame_done.
- pclk falling edges have no effect.
- Changes on buttons outside LATCH do not affect the frame in progress.
- Reset asserted mid-frame: state, count and outputs take their reset values on the next clk edge.

Optional Feature:
- Macro: SNES_PAD_WATCHDOG_EN.
- Defined:
  - A counter clears on every synced pclk or latch edge and increments in SHIFT and LATCH.
  - Reaching TIMEOUT_CYCLES forces IDLE, count=0, data_out=1, no frame_done.
  - Recovers from a host that stalls mid-frame.
- Undefined: no counter is built; SHIFT and LATCH wait indefinitely.

Test Plan:
- buttons=16'hA5C3; pulse latch 12 cycles; 16 pclk low/high pulses of 64 cycles each -> data_out before each rise is ~bits 15..0, i.e. 0,1,0,1,1,0,1,0,0,0,1,1,1,1,0,0; frame_done pulses once after the 16th rise; data_out=1.
- Loopback with the host pad reader, buttons=16'h0001 -> reader nesState=16'hFFFE and its done asserted; emulator frame_done asserted.
- buttons changes 16'h1234 -> 16'hFFFF while latch is high -> frame shifts ~16'hFFFF; a change to 16'h0000 during SHIFT has no effect.
- Latch rise after the 5th pclk rise, buttons=16'h8000 -> back in LATCH, data_out=0, no frame_done; the new frame completes normally.
- Reset for 1 cycle after the 8th bit -> data_out=1, busy=0 next cycle; no spurious edge when reset releases with pclk_in=1.
- With SNES_PAD_WATCHDOG_EN, TIMEOUT_CYCLES=256: stop pclk after 3 bits -> IDLE and data_out=1 at cycle 256 after the last edge, frame_done stays 0.
